mem_arbiter: RTL and testbench

- Sequences the single shared RAM port between the instruction-fetch requester (I side) and the data-memory requester (D side) of the pipelined MIPS datapath.
- Ownership is granted through a registered FSM and held until RAM reports ACCESS. This wait/hit handshake is what the pipeline's ihit/dhit stall logic consumes.
- Data requests have priority. A starvation counter guarantees forward progress for instruction fetch.

---
 rtl/cpu_types_pkg.sv | 23 ++
 rtl/mem_arb_starve.sv | 39 +++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Types shared across the MIPS datapath: the RAM handshake state, the
// shared-port arbiter FSM states, and the default starvation limit.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IGNT = 2'd1,
    ARB_DGNT = 2'd2,
    ARB_DONE = 2'd3
  } arb_state_t;

  localparam int MEM_ARB_STARVE_DEFAULT = 8;

endpackage

// File: rtl/mem_arb_starve.sv
// Saturating count of consecutive cycles the instruction side has waited
// without ownership; at_limit forces the next idle grant to the I side.
module mem_arb_starve import cpu_types_pkg::*; #(
  parameter int LIMIT = MEM_ARB_STARVE_DEFAULT,
  parameter int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic CLK,
  input  logic RST,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state is written with <= only, so every flop samples
  // the values from before the edge regardless of block ordering.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == LIMIT_C);

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single RAM port between instruction fetch and data memory.
// Define MEM_ARB_STATS_EN to add completion/stall counters (icount, dcount, stallcount).
module mem_arbiter import cpu_types_pkg::*; #(
  parameter int STARVE_LIMIT = MEM_ARB_STARVE_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
`ifdef MEM_ARB_STATS_EN
  output logic [31:0] icount,
  output logic [31:0] dcount,
  output logic [31:0] stallcount,
`endif
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t state_q, state_d;
  logic       dreq;
  logic       ihit, dhit;
  logic       at_limit;

  assign dreq = dREN | dWEN;

  mem_arb_starve #(
    .LIMIT (STARVE_LIMIT),
    .CNT_W (CNT_W)
  ) u_starve (
    .CLK      (CLK),
    .RST      (RST),
    .inc      (iREN && (state_q != ARB_IGNT)),
    .clr      (ihit),
    .at_limit (at_limit)
  );

  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that
    // skipped one would otherwise infer a latch.
    state_d  = state_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ihit     = 1'b0;
    dhit     = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (dreq && !at_limit) begin
          state_d = ARB_DGNT;
        end else if (iREN) begin
          state_d = ARB_IGNT;
        end
      end

      ARB_IGNT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (!iREN) begin
          state_d = ARB_IDLE;
        end else if (ramstate == ACCESS) begin
          ihit    = 1'b1;
          iwait   = 1'b0;
          iload   = ramload;
          state_d = ARB_DONE;
        end else if (ramstate == ERROR) begin
          state_d = ARB_IDLE;
        end
      end

      ARB_DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        // A write wins over a read when both are raised together.
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (!dreq) begin
          state_d = ARB_IDLE;
        end else if (ramstate == ACCESS) begin
          dhit    = 1'b1;
          dwait   = 1'b0;
          dload   = dWEN ? '0 : ramload;
          state_d = ARB_DONE;
        end else if (ramstate == ERROR) begin
          state_d = ARB_IDLE;
        end
      end

      // Turnaround keeps a requester that is still high from a second hit.
      ARB_DONE: state_d = ARB_IDLE;

      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [31:0] icount_q, icount_d;
  logic [31:0] dcount_q, dcount_d;
  logic [31:0] stallcount_q, stallcount_d;

  always_comb begin
    icount_d     = icount_q + 32'(ihit);
    dcount_d     = dcount_q + 32'(dhit);
    stallcount_d = stallcount_q + 32'((iREN | dreq) & ~ihit & ~dhit);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      icount_q     <= '0;
      dcount_q     <= '0;
      stallcount_q <= '0;
    end else begin
      icount_q     <= icount_d;
      dcount_q     <= dcount_d;
      stallcount_q <= stallcount_d;
    end
  end

  assign icount     = icount_q;
  assign dcount     = dcount_q;
  assign stallcount = stallcount_q;
`endif

  a_single_hit : assert property (@(posedge CLK) disable iff (RST)
    !((iwait == 1'b0) && (dwait == 1'b0)));

  a_enable_owner : assert property (@(posedge CLK) disable iff (RST)
    (ramREN || ramWEN) |-> ((state_q == ARB_IGNT) || (state_q == ARB_DGNT)));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked against an ownership model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int LIMIT = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = '0;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore;
  logic [31:0] ramload = '0;
  ramstate_t   ramstate = FREE;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] icount, dcount, stallcount;
`endif

  always #5 CLK = ~CLK;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
`ifdef MEM_ARB_STATS_EN
    .icount     (icount),
    .dcount     (dcount),
    .stallcount (stallcount),
`endif
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the port (none / I / D / cooling off) and how long I has waited.
  localparam int OWN_NONE = 0, OWN_I = 1, OWN_D = 2, OWN_COOL = 3;
  int  owner = OWN_NONE;
  int  i_waited = 0;
  bit  cmp_en = 1'b0;
  int  n_ihit = 0, n_dhit = 0, ren_cycles = 0;
  bit  ihit_last = 1'b0, dhit_last = 1'b0;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] m_icnt = '0, m_dcnt = '0, m_stall = '0;
`endif

  always @(negedge CLK) begin : compare
    logic [31:0] e_addr, e_store, e_iload, e_dload;
    logic        e_ren, e_wen, e_iwait, e_dwait, dreq;
    int          nxt;
    dreq    = dREN | dWEN;
    e_addr  = '0; e_store = '0; e_iload = '0; e_dload = '0;
    e_ren   = 1'b0; e_wen = 1'b0; e_iwait = 1'b1; e_dwait = 1'b1;
    if (owner == OWN_I) begin
      e_addr = iaddr;
      e_ren  = iREN;
      if (iREN && ramstate == ACCESS) begin
        e_iwait = 1'b0;
        e_iload = ramload;
      end
    end else if (owner == OWN_D) begin
      e_addr  = daddr;
      e_store = dstore;
      if (dreq) begin
        e_wen = dWEN;
        e_ren = !dWEN;
        if (ramstate == ACCESS) begin
          e_dwait = 1'b0;
          e_dload = dWEN ? 32'h0 : ramload;
        end
      end
    end

    if (cmp_en) begin
      check("ramREN", ramREN, e_ren);
      check("ramWEN", ramWEN, e_wen);
      check("ramaddr", ramaddr, e_addr);
      check("ramstore", ramstore, e_store);
      check("iwait", iwait, e_iwait);
      check("dwait", dwait, e_dwait);
      check("iload", iload, e_iload);
      check("dload", dload, e_dload);
`ifdef MEM_ARB_STATS_EN
      check("icount", icount, m_icnt);
      check("dcount", dcount, m_dcnt);
      check("stallcount", stallcount, m_stall);
`endif
    end
    ihit_last = (iwait === 1'b0);
    dhit_last = (dwait === 1'b0);
    if (ihit_last) n_ihit++;
    if (dhit_last) n_dhit++;
    if (ramREN === 1'b1) ren_cycles++;

`ifdef MEM_ARB_STATS_EN
    if (!e_iwait) m_icnt = m_icnt + 1;
    if (!e_dwait) m_dcnt = m_dcnt + 1;
    if ((iREN || dreq) && e_iwait && e_dwait) m_stall = m_stall + 1;
    if (RST) begin m_icnt = '0; m_dcnt = '0; m_stall = '0; end
`endif

    nxt = owner;
    case (owner)
      OWN_NONE: if (dreq && i_waited < LIMIT) nxt = OWN_D;
                else if (iREN) nxt = OWN_I;
      OWN_I:    if (!iREN || ramstate == ERROR) nxt = OWN_NONE;
                else if (ramstate == ACCESS) nxt = OWN_COOL;
      OWN_D:    if (!dreq || ramstate == ERROR) nxt = OWN_NONE;
                else if (ramstate == ACCESS) nxt = OWN_COOL;
      default:  nxt = OWN_NONE;
    endcase
    if (owner == OWN_I && iREN && ramstate == ACCESS) i_waited = 0;
    else if (iREN && owner != OWN_I && i_waited < LIMIT) i_waited++;
    owner = nxt;
    if (RST) begin
      owner = OWN_NONE;
      i_waited = 0;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramstate = FREE; ramload = '0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    clear_inputs();
    tick();
    RST = 1'b0;
  endtask

  function automatic ramstate_t rand_ramstate();
    int r;
    r = $urandom_range(0, 9);
    if (r < 2) return FREE;
    if (r < 6) return BUSY;
    if (r < 9) return ACCESS;
    return ERROR;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int base_a, base_b, dcnt, rounds, i_rand0;
    clear_inputs();
    RST = 1'b1;
    tick();
    cmp_en = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    check("rst_ramREN", ramREN, 1'b0);
    check("rst_ramaddr", ramaddr, 32'h0);
    check("rst_iwait", iwait, 1'b1);
    check("rst_dwait", dwait, 1'b1);

    // Single I read, ACCESS on third granted cycle.
    do_reset();
    base_a = ren_cycles; base_b = n_ihit;
    iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY;
    tick();
    #1 check("iread_addr", ramaddr, 32'h40);
    check("iread_ren", ramREN, 1'b1);
    tick();
    tick();
    ramstate = ACCESS; ramload = 32'h8C22_0004;
    #1 check("iread_hit", iwait, 1'b0);
    check("iread_iload", iload, 32'h8C22_0004);
    tick();
    ramstate = FREE; iREN = 1'b0;
    #1 check("iread_done_iwait", iwait, 1'b1);
    check("iread_done_ren", ramREN, 1'b0);
    tick();
    check("iread_ren_cycles", ren_cycles - base_a, 3);
    check("iread_hits", n_ihit - base_b, 1);

    // Simultaneous requests: D first, I after turnaround.
    do_reset();
    iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h200;
    ramstate = ACCESS; ramload = 32'h1111_2222;
    tick();
    #1 check("sim_d_addr", ramaddr, 32'h200);
    check("sim_d_hit", dwait, 1'b0);
    check("sim_d_load", dload, 32'h1111_2222);
    check("sim_i_wait", iwait, 1'b1);
    tick();
    dREN = 1'b0;
    tick();
    #1 check("sim_idle_ren", ramREN, 1'b0);
    tick();
    #1 check("sim_i_addr", ramaddr, 32'h44);
    check("sim_i_hit", iwait, 1'b0);
    tick();
    iREN = 1'b0; ramstate = FREE;
    tick();

    // Write precedence.
    do_reset();
    base_b = n_dhit;
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF; ramstate = BUSY;
    tick();
    #1 check("wr_wen", ramWEN, 1'b1);
    check("wr_ren", ramREN, 1'b0);
    check("wr_store", ramstore, 32'hDEAD_BEEF);
    check("wr_addr", ramaddr, 32'h100);
    check("wr_wait_busy", dwait, 1'b1);
    tick();
    ramstate = ACCESS; ramload = 32'h5555_AAAA;
    #1 check("wr_hit", dwait, 1'b0);
    check("wr_dload", dload, 32'h0);
    tick();
    dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    #1 check("wr_done_wait", dwait, 1'b1);
    tick();
    check("wr_hits", n_dhit - base_b, 1);

    // Starvation guard: three D hits, then I forced through, twice.
    do_reset();
    dREN = 1'b1; daddr = 32'h300; iREN = 1'b1; iaddr = 32'h80; ramstate = ACCESS;
    dcnt = 0; rounds = 0;
    for (int c = 0; c < 60 && rounds < 2; c++) begin
      tick();
      #2;
      if (dwait === 1'b0) dcnt++;
      if (iwait === 1'b0) begin
        check($sformatf("starve_round%0d_dhits", rounds), dcnt, 3);
        dcnt = 0;
        rounds++;
      end
    end
    check("starve_rounds", rounds, 2);
    dREN = 1'b0; iREN = 1'b0; ramstate = FREE;
    tick();

    // Abort: D drops before ACCESS.
    do_reset();
    base_b = n_dhit;
    dREN = 1'b1; daddr = 32'h500; ramstate = BUSY;
    tick();
    #1 check("abort_ren_on", ramREN, 1'b1);
    tick();
    dREN = 1'b0;
    #1 check("abort_ren_off", ramREN, 1'b0);
    check("abort_dwait", dwait, 1'b1);
    tick();
    tick();
    check("abort_no_hit", n_dhit - base_b, 0);

    // ERROR while I granted: back to idle, then re-granted.
    do_reset();
    iREN = 1'b1; iaddr = 32'h600; ramstate = BUSY;
    tick();
    ramstate = ERROR;
    #1 check("err_iwait", iwait, 1'b1);
    tick();
    ramstate = BUSY;
    #1 check("err_idle_ren", ramREN, 1'b0);
    check("err_idle_iwait", iwait, 1'b1);
    tick();
    #1 check("err_regrant_ren", ramREN, 1'b1);
    check("err_regrant_addr", ramaddr, 32'h600);
    ramstate = ACCESS; ramload = 32'h0BAD_F00D;
    #1 check("err_regrant_hit", iwait, 1'b0);
    tick();
    iREN = 1'b0; ramstate = FREE;
    tick();

    // Reset mid-grant.
    do_reset();
    dREN = 1'b1; daddr = 32'h700; ramstate = BUSY;
    tick();
    tick();
    RST = 1'b1;
    #1 check("rstmid_still_granted", ramREN, 1'b1);
    tick();
    RST = 1'b0;
    #1 check("rstmid_ren", ramREN, 1'b0);
    check("rstmid_wen", ramWEN, 1'b0);
    check("rstmid_iwait", iwait, 1'b1);
    check("rstmid_dwait", dwait, 1'b1);
`ifdef MEM_ARB_STATS_EN
    check("rstmid_icount", icount, 32'h0);
    check("rstmid_dcount", dcount, 32'h0);
    check("rstmid_stallcount", stallcount, 32'h0);
`endif
    dREN = 1'b0; ramstate = FREE;
    tick();

    // Randomized traffic against the model.
    do_reset();
    i_rand0 = n_ihit + n_dhit;
    for (int c = 0; c < 4000; c++) begin
      tick();
      RST = ($urandom_range(0, 599) == 0);
      if (iREN) begin
        if (ihit_last) begin
          iREN  = ($urandom_range(0, 3) != 0);
          iaddr = $urandom;
        end else if ($urandom_range(0, 39) == 0) begin
          iREN = 1'b0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        iREN  = 1'b1;
        iaddr = $urandom;
      end
      if (dREN || dWEN) begin
        if (dhit_last || $urandom_range(0, 39) == 0) begin
          dREN = 1'b0; dWEN = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 2))
          0:       begin dREN = 1'b1; dWEN = 1'b0; end
          1:       begin dREN = 1'b0; dWEN = 1'b1; end
          default: begin dREN = 1'b1; dWEN = 1'b1; end
        endcase
        daddr  = $urandom;
        dstore = $urandom;
      end
      ramstate = rand_ramstate();
      ramload  = $urandom;
    end
    RST = 1'b0;
    clear_inputs();
    tick();
    tick();
    check("rand_activity", (n_ihit + n_dhit - i_rand0) > 100, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
